// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte-stream requesters with message locking.
// Optional forced release of an idle lock is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arb #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ack,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               arb_busy,
  output logic               timeout_err
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("uart_tx_arb: N_REQ must be 2..8 and TIMEOUT_CYC at least 2");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANT     = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [N_REQ-1:0]   grant_r;
  logic [IDX_W-1:0]   gidx_r;
  logic [IDX_W-1:0]   ptr_r;
  logic [7:0]         tx_data_r;
  logic               last_r;
  logic               timeout_err_r;
  logic [IDX_W-1:0]   pick_s;
  logic               any_req_s;
  logic               req_g_s;
  logic               timeout_hit_s;
  logic               tx_start_s;
  logic [N_REQ-1:0]   req_ack_s;
  logic               arb_busy_s;

  // Scan upward from ptr+1 with wrap; iterating downward lets the nearest set bit win.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    sel = p;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(p) + k) % N_REQ);
      if (r[idx]) begin
        sel = idx;
      end else begin
        sel = sel;
      end
    end
    return sel;
  endfunction

  // Arbitration pick and owner request decode.
  always_comb begin
    pick_s    = rr_pick(req, ptr_r);
    any_req_s = |req;
    req_g_s   = req[gidx_r];
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] tout_cnt_r;

  // Counts idle cycles of a locked owner; cleared whenever a byte is taken or the lock ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      tout_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_GRANT && !req_g_s && !timeout_hit_s) begin
      tout_cnt_r <= tout_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (state_r == ST_GRANT) begin
      tout_cnt_r <= {CNT_W{1'b0}};
    end else begin
      tout_cnt_r <= tout_cnt_r;
    end
  end

  // Forced release once the owner has idled for TIMEOUT_CYC cycles.
  always_comb begin
    timeout_hit_s = (state_r == ST_GRANT) && !req_g_s &&
                    (tout_cnt_r == CNT_W'(TIMEOUT_CYC - 1));
  end
`else
  // Without forced release the lock is held indefinitely.
  always_comb begin
    timeout_hit_s = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_next_s = ST_GRANT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (req_g_s) begin
          state_next_s = ST_SEND;
        end else if (timeout_hit_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_GRANT;
        end
      end
      ST_SEND: begin
        state_next_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_next_s = ST_WAIT_DONE;
        end else begin
          state_next_s = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_busy) begin
          state_next_s = ST_WAIT_DONE;
        end else if (last_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_GRANT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from state and registered owner only.
  always_comb begin
    tx_start_s = 1'b0;
    req_ack_s  = {N_REQ{1'b0}};
    arb_busy_s = (state_r != ST_IDLE);
    case (state_r)
      ST_SEND: begin
        tx_start_s = 1'b1;
        req_ack_s  = grant_r;
      end
      default: begin
        tx_start_s = 1'b0;
        req_ack_s  = {N_REQ{1'b0}};
      end
    endcase
  end

  // Owner, rotation pointer, byte capture and timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_r       <= {N_REQ{1'b0}};
      gidx_r        <= {IDX_W{1'b0}};
      ptr_r         <= IDX_W'(N_REQ - 1);
      tx_data_r     <= 8'h00;
      last_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      timeout_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            grant_r <= ONE_HOT0 << pick_s;
            gidx_r  <= pick_s;
          end else begin
            grant_r <= {N_REQ{1'b0}};
          end
        end
        ST_GRANT: begin
          if (req_g_s) begin
            tx_data_r <= req_data[{gidx_r, 3'b000} +: 8];
            last_r    <= req_last[gidx_r];
          end else if (timeout_hit_s) begin
            grant_r       <= {N_REQ{1'b0}};
            ptr_r         <= gidx_r;
            timeout_err_r <= 1'b1;
          end else begin
            grant_r <= grant_r;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy && last_r) begin
            grant_r <= {N_REQ{1'b0}};
            ptr_r   <= gidx_r;
          end else begin
            grant_r <= grant_r;
          end
        end
        default: begin
          grant_r <= grant_r;
        end
      endcase
    end
  end

  assign grant       = grant_r;
  assign req_ack     = req_ack_s;
  assign tx_start    = tx_start_s;
  assign tx_data     = tx_data_r;
  assign arb_busy    = arb_busy_s;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: directed requester streams, queued expected bytes, monitor on tx_start.
module tb_uart_tx_arb;

  localparam int NR    = 4;
  localparam int FRAME = 6;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         gap;
  } ent_t;

  typedef struct {
    int         idx;
    logic [7:0] d;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ack;
  logic [NR-1:0]   grant;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            arb_busy;
  logic            timeout_err;

  ent_t rq [NR][$];
  exp_t exp_q [$];
  int   wcnt [NR];
  int   ack_cnt [NR];
  int   checks = 0;
  int   errors = 0;
  logic [NR-1:0] grant_prev = '0;

  uart_tx_arb #(.N_REQ(NR), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_last(req_last),
    .req_ack(req_ack), .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises two cycles after start and lasts FRAME cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat (2) @(negedge clk);
        tx_busy = 1'b1;
        repeat (FRAME) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  // Requester models: present queue head after its gap, pop on ack.
  initial begin
    req = '0; req_data = '0; req_last = '0;
    for (int i = 0; i < NR; i++) wcnt[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req_ack[i] && rq[i].size() > 0) begin
          void'(rq[i].pop_front());
          wcnt[i] = 0;
        end
        if (rq[i].size() > 0 && wcnt[i] >= rq[i][0].gap) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = rq[i][0].d;
          req_last[i] = rq[i][0].l;
        end else begin
          req[i] = 1'b0;
          if (rq[i].size() > 0) wcnt[i]++;
        end
      end
    end
  end

  // Monitor: compare every transmitted byte against the scoreboard.
  initial begin
    exp_t e;
    logic [NR-1:0] eg;
    for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (tx_start) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_tx: got tx_data=%02h grant=%b, required no transmission", tx_data, grant);
          end else begin
            e = exp_q.pop_front();
            eg = 4'b0001 << e.idx;
            if (tx_data !== e.d || grant !== eg || req_ack !== eg) begin
              errors++;
              $display("FAIL byte_order: got data=%02h grant=%b ack=%b, required data=%02h grant=%b ack=%b",
                       tx_data, grant, req_ack, e.d, eg, eg);
            end
          end
        end
        if (req_ack !== '0 && !tx_start) begin
          checks++;
          errors++;
          $display("FAIL ack_without_start: got req_ack=%b tx_start=0, required no ack", req_ack);
        end
        if (grant_prev !== '0 && grant !== '0) begin
          checks++;
          if (grant !== grant_prev) begin
            errors++;
            $display("FAIL grant_lock: got grant=%b, required %b", grant, grant_prev);
          end
        end
`ifndef UART_ARB_TIMEOUT_EN
        checks++;
        if (timeout_err !== 1'b0) begin
          errors++;
          $display("FAIL timeout_err_tied: got %b, required 0", timeout_err);
        end
`endif
        for (int i = 0; i < NR; i++) if (req_ack[i]) ack_cnt[i]++;
      end
      grant_prev = grant;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req_v);
    end
  endtask

  task automatic push_exp(input int idx, input logic [7:0] d);
    exp_t e;
    e.idx = idx; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_req(input int idx, input logic [7:0] d, input logic l, input int gap);
    ent_t e;
    e.d = d; e.l = l; e.gap = gap;
    rq[idx].push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || arb_busy || tx_busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, (n >= budget) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic wait_grant(input string name, input logic [NR-1:0] g, input int budget);
    int n = 0;
    while (grant !== g && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {28'd0, grant}, {28'd0, g});
  endtask

  initial begin
    int a0;
    int a_base [NR];
    int n;
    int pulses;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_arb_busy", {31'd0, arb_busy}, 32'd0);
    check("rst_req_ack", {28'd0, req_ack}, 32'd0);
    check("rst_timeout_err", {31'd0, timeout_err}, 32'd0);

    // Single byte from requester 0
    a0 = ack_cnt[0];
    push_exp(0, 8'hA5);
    push_req(0, 8'hA5, 1'b1, 0);
    n = 0;
    do begin @(posedge clk); n++; end while (!req[0] && n < 20);
    #1 check("t1_grant_latency", {28'd0, grant}, 32'b0001);
    drain("t1_drain", 200);
    check("t1_grant_idle", {28'd0, grant}, 32'd0);
    check("t1_arb_idle", {31'd0, arb_busy}, 32'd0);
    check("t1_ack_count", ack_cnt[0] - a0, 32'd1);

    // All four requesting, four single-byte messages each
    do_reset();
    for (int i = 0; i < NR; i++) a_base[i] = ack_cnt[i];
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < NR; i++) begin
        push_exp(i, 8'(8'h10 * r + i));
        push_req(i, 8'(8'h10 * r + i), 1'b1, 0);
      end
    drain("t2_drain", 2000);
    for (int i = 0; i < NR; i++) check("t2_ack_count", ack_cnt[i] - a_base[i], 32'd4);

    // Locked 3-byte message from 2, requester 1 arrives mid-message
    a0 = ack_cnt[2];
    push_exp(2, 8'h11); push_exp(2, 8'h22); push_exp(2, 8'h33); push_exp(1, 8'h44);
    push_req(2, 8'h11, 1'b0, 0); push_req(2, 8'h22, 1'b0, 0); push_req(2, 8'h33, 1'b1, 0);
    n = 0;
    while (ack_cnt[2] == a0 && n < 100) begin @(posedge clk); #1; n++; end
    check("t3_first_ack", (ack_cnt[2] > a0) ? 32'd1 : 32'd0, 32'd1);
    push_req(1, 8'h44, 1'b1, 0);
    drain("t3_drain", 500);

`ifndef UART_ARB_TIMEOUT_EN
    // Owner idles 100 cycles mid-message while 3 waits
    a0 = ack_cnt[0];
    push_exp(0, 8'h01); push_exp(0, 8'h02); push_exp(3, 8'h55);
    push_req(0, 8'h01, 1'b0, 0); push_req(0, 8'h02, 1'b1, 100);
    wait_grant("t4_grant0", 4'b0001, 50);
    push_req(3, 8'h55, 1'b1, 0);
    n = 0;
    while (ack_cnt[0] == a0 && n < 100) begin @(posedge clk); #1; n++; end
    repeat (60) @(posedge clk);
    #1;
    check("t4_lock_grant", {28'd0, grant}, 32'b0001);
    check("t4_lock_busy", {31'd0, arb_busy}, 32'd1);
    check("t4_lock_pending", exp_q.size(), 32'd2);
    drain("t4_drain", 600);
`else
    // Owner idles mid-message; forced release then requester 1
    push_exp(0, 8'h01); push_exp(1, 8'h99);
    push_req(0, 8'h01, 1'b0, 0);
    wait_grant("t4_grant0", 4'b0001, 50);
    push_req(1, 8'h99, 1'b1, 0);
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (timeout_err) begin
        pulses++;
        check("t4_timeout_grant", {28'd0, grant}, 32'd0);
      end
    end
    check("t4_timeout_pulses", pulses, 32'd1);
    drain("t4_drain", 300);
`endif

    // Reset during WAIT_DONE with requester 1 granted
    push_exp(1, 8'h66);
    push_req(1, 8'h66, 1'b0, 0);
    n = 0;
    while (!(tx_busy && grant === 4'b0010) && n < 100) begin @(posedge clk); #1; n++; end
    check("t5_in_frame", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_rst_grant", {28'd0, grant}, 32'd0);
    check("t5_rst_tx_start", {31'd0, tx_start}, 32'd0);
    check("t5_rst_arb_busy", {31'd0, arb_busy}, 32'd0);
    n = 0;
    while (tx_busy && n < 50) begin @(posedge clk); #1; n++; end
    push_exp(0, 8'h77); push_exp(1, 8'h88);
    push_req(0, 8'h77, 1'b1, 0); push_req(1, 8'h88, 1'b1, 0);
    drain("t5_drain", 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

endmodule
